puf_measure_ctrl: RTL and testbench

- Measurement sequencer for the ring-oscillator PUF; sits directly upstream of the 4-bit window timer and drives its SCLR/CE, consuming its time_stop.
- Per response bit: clears the RO edge counters, opens a timed count window, waits for synchronizer settle, compares the two RO counts, and shifts one bit into the response register.
- Produces an N-bit response with done/err/tie status for the PS-side register interface.

---
 rtl/puf_pkg.sv | 7 +
 rtl/puf_measure_ctrl_if.sv | 29 ++
 rtl/puf_bit_compare.sv | 12 +
 rtl/puf_measure_ctrl.sv | 121 ++++++++++++
 tb/tb_puf_measure_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared types and defaults for the RO-PUF measurement sequencer.
package puf_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, WINDOW, SETTLE, COMPARE, DONE} state_e;
  localparam int RESP_BITS_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int RO_PAIRS = RESP_BITS_DEF;
endpackage

// File: rtl/puf_measure_ctrl_if.sv
// puf_measure_ctrl_if: host, window-timer and RO-counter signals of the sequencer.
interface puf_measure_ctrl_if #(
  parameter int RESP_BITS = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
);
  logic start;
  logic tmr_stop;
  logic [CNT_W-1:0] ro_cnt_a;
  logic [CNT_W-1:0] ro_cnt_b;
  logic tmr_sclr;
  logic tmr_ce;
  logic ro_clr;
  logic ro_en;
  logic [IDX_W-1:0] pair_sel;
  logic busy;
  logic done;
  logic err;
  logic [IDX_W:0] tie_cnt;
  logic [RESP_BITS-1:0] response;
  modport master (
    input start, tmr_stop, ro_cnt_a, ro_cnt_b,
    output tmr_sclr, tmr_ce, ro_clr, ro_en, pair_sel, busy, done, err, tie_cnt, response
  );
  modport slave (
    output start, tmr_stop, ro_cnt_a, ro_cnt_b,
    input tmr_sclr, tmr_ce, ro_clr, ro_en, pair_sel, busy, done, err, tie_cnt, response
  );
endinterface

// File: rtl/puf_bit_compare.sv
// puf_bit_compare: unsigned RO count compare yielding the response bit and a tie flag.
module puf_bit_compare #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] a_i,
  input  logic [CNT_W-1:0] b_i,
  output logic             bit_o,
  output logic             tie_o
);
  assign bit_o = a_i > b_i;
  assign tie_o = a_i == b_i;
endmodule

// File: rtl/puf_measure_ctrl.sv
// puf_measure_ctrl: sequences clear/window/settle/compare per RO pair to build the PUF response.
module puf_measure_ctrl
  import puf_pkg::*;
#(
  parameter int RESP_BITS = RESP_BITS_DEF,
  parameter int IDX_W = 3,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int WDOG_CYC = 64
) (
  input logic CLK,
  input logic SCLR,
  puf_measure_ctrl_if.master bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [IDX_W:0] TIE_MAX = (IDX_W + 1)'(RESP_BITS);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] wdog_q, wdog_d;
  logic [3:0] settle_q, settle_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [IDX_W:0] tie_q, tie_d;
  logic err_q, err_d;
  logic sclr_q, clr_q, ce_q, en_q, busy_q, done_q;
  logic cmp_bit, cmp_tie;

  puf_bit_compare #(.CNT_W(CNT_W)) u_cmp (
    .a_i  (bus.ro_cnt_a),
    .b_i  (bus.ro_cnt_b),
    .bit_o(cmp_bit),
    .tie_o(cmp_tie)
  );

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wdog_d = wdog_q;
    settle_d = settle_q;
    resp_d = resp_q;
    tie_d = tie_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CLEAR;
        idx_d = '0;
        resp_d = '0;
        tie_d = '0;
        err_d = 1'b0;
      end
      CLEAR: begin
        state_d = WINDOW;
        wdog_d = '0;
      end
      // tmr_stop has priority over a watchdog expiry in the same cycle
      WINDOW: if (bus.tmr_stop) begin
        state_d = SETTLE;
        settle_d = '0;
      end else if (wdog_q == WDOG_LAST) begin
        state_d = DONE;
        err_d = 1'b1;
      end else wdog_d = wdog_q + 8'd1;
      SETTLE: if (settle_q == SETTLE_LAST) state_d = COMPARE;
        else settle_d = settle_q + 4'd1;
      COMPARE: begin
        resp_d[idx_q] = cmp_bit;
        tie_d = (cmp_tie && tie_q != TIE_MAX) ? tie_q + 1'b1 : tie_q;
        state_d = (idx_q == LAST_IDX) ? DONE : CLEAR;
        idx_d = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state_q <= IDLE;
      idx_q <= '0;
      wdog_q <= '0;
      settle_q <= '0;
      resp_q <= '0;
      tie_q <= '0;
      err_q <= 1'b0;
      sclr_q <= 1'b1;
      clr_q <= 1'b1;
      ce_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wdog_q <= wdog_d;
      settle_q <= settle_d;
      resp_q <= resp_d;
      tie_q <= tie_d;
      err_q <= err_d;
      sclr_q <= state_d inside {IDLE, CLEAR, DONE};
      clr_q <= state_d inside {IDLE, CLEAR, DONE};
      ce_q <= state_d == WINDOW;
      en_q <= state_d == WINDOW;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
    end
  end

  assign bus.tmr_sclr = sclr_q;
  assign bus.ro_clr = clr_q;
  assign bus.tmr_ce = ce_q;
  assign bus.ro_en = en_q;
  assign bus.pair_sel = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.tie_cnt = tie_q;
  assign bus.response = resp_q;
endmodule

// File: tb/tb_puf_measure_ctrl.sv
// tb_puf_measure_ctrl: randomized runs against a per-bit timing/response model of the sequencer.
module tb_puf_measure_ctrl;
  localparam int NB = 8;
  localparam int SETTLE = 2;
  localparam int WDOG = 64;

  logic clk = 1'b0;
  logic sclr = 1'b1;
  int checks = 0;
  int failures = 0;
  int win = 15;
  bit stop_dis = 1'b0;
  int tcnt = 0;
  logic [15:0] ra [NB];
  logic [15:0] rb [NB];

  always #5 clk = ~clk;

  puf_measure_ctrl_if #(.RESP_BITS(NB), .IDX_W(3), .CNT_W(16)) bus ();

  puf_measure_ctrl #(.RESP_BITS(NB), .IDX_W(3), .CNT_W(16), .SETTLE_CYC(SETTLE), .WDOG_CYC(WDOG)) dut (
    .CLK (clk),
    .SCLR(sclr),
    .bus (bus.master)
  );

  always @(posedge clk) tcnt <= bus.tmr_sclr ? 0 : (bus.tmr_ce ? tcnt + 1 : tcnt);
  assign bus.tmr_stop = !stop_dis && bus.tmr_ce && (tcnt == win - 1);
  assign bus.ro_cnt_a = ra[bus.pair_sel];
  assign bus.ro_cnt_b = rb[bus.pair_sel];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int w, input bit hold, input bit inj, input bit ds, input bit trace);
    int per, n, b, p, ties;
    bit done_seen, injected, ce_e;
    logic [NB-1:0] er;
    per = 4 + SETTLE - 2 + w;
    win = w;
    stop_dis = hold;
    er = '0;
    ties = 0;
    for (int i = 0; i < NB; i++) begin
      er[i] = ra[i] > rb[i];
      ties += (ra[i] == rb[i]) ? 1 : 0;
    end
    done_seen = 0;
    injected = 0;
    n = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int c = 1; c <= 2000 && !done_seen; c++) begin
      n = c;
      chk("busy_run", bus.busy, 1);
      if (c == 1) chk("err_cleared", bus.err, 0);
      if (trace && c <= NB * per) begin
        b = (c - 1) / per;
        p = (c - 1) % per;
        ce_e = p >= 1 && p <= w;
        chk("trace", {bus.tmr_sclr, bus.ro_clr, bus.tmr_ce, bus.ro_en, bus.pair_sel},
            {p == 0, p == 0, ce_e, ce_e, 3'(b)});
      end
      if (bus.done) done_seen = 1;
      else begin
        if (inj && !injected && bus.pair_sel == 3'd4) begin
          bus.start = 1'b1;
          injected = 1;
        end
        @(negedge clk) bus.start = 1'b0;
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    else begin
      chk("run_len", n, hold ? 2 + WDOG : NB * per + 1);
      chk("response", bus.response, hold ? 0 : er);
      chk("tie_cnt", bus.tie_cnt, hold ? 0 : ties);
      chk("err", bus.err, hold);
      if (ds) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      chk("done_once", bus.done, 0);
      chk("busy_after", bus.busy, 0);
      chk("hold_resp", bus.response, hold ? 0 : er);
    end
    stop_dis = 1'b0;
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {bus.tmr_sclr, bus.ro_clr, bus.tmr_ce, bus.ro_en, bus.busy, bus.done, bus.err},
        7'b1100000);
    chk("rst_data", {bus.pair_sel, bus.tie_cnt, bus.response}, 0);
    sclr = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold", bus.busy, 0);

    for (int i = 0; i < NB; i++) begin
      ra[i] = (i % 2 == 0) ? 16'h0100 : 16'h00F0;
      rb[i] = (i % 2 == 0) ? 16'h00F0 : 16'h0100;
    end
    run(15, 0, 0, 0, 1);
    chk("resp_55", bus.response, 8'h55);

    for (int i = 0; i < NB; i++) begin
      ra[i] = (i == 2 || i == 5) ? 16'h0080 : 16'h0100;
      rb[i] = (i == 2 || i == 5) ? 16'h0080 : 16'h00F0;
    end
    run(15, 0, 0, 1, 0);
    chk("resp_db", {bus.tie_cnt, bus.response}, {4'd2, 8'hDB});

    run(15, 1, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NB; i++) begin
        ra[i] = 16'($urandom);
        rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 16'($urandom);
      end
      run($urandom_range(2, 30), 0, r % 2 == 1, r % 3 == 0, r < 2);
    end

    run(WDOG, 0, 0, 0, 0);
    run(10, 0, 1, 0, 1);

    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      if (bus.pair_sel == 3'd3 && bus.tmr_ce) seen = 1;
      else @(negedge clk);
    end
    chk("reach_bit3", seen, 1);
    sclr = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ctl", {bus.tmr_sclr, bus.ro_clr, bus.tmr_ce, bus.busy, bus.done}, 5'b11000);
    chk("abort_data", {bus.response, bus.tie_cnt, bus.err}, 0);
    @(negedge clk) sclr = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("abort_quiet", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
